// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory for the MIPS MEM stage.
// Little-endian byte lanes, sb/sh/sw stores, lb/lbu/lh/lhu/lw loads with
// extension, a registered one-cycle response, misalignment flagging and a
// hardware zero-clear sweep that runs after reset and on request.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready is low while the sweep runs and in any cycle where clear is high.
// Every accepted request produces exactly one rsp_valid pulse in the cycle
// after the accepting edge. The response has no back-pressure.
module data_mem_ctrl #(
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              clear,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misalign,
  output logic              busy,
  output logic              state_dbg
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WORD_W;
  localparam logic [WORD_W-1:0] LAST_PTR = '1;
  localparam logic [WORD_W-1:0] PTR_ONE  = 1;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] ptr, ptr_nxt;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              fault;
  logic [WORD_W-1:0] widx;
  logic [31:0]       rword;
  logic [31:0]       shifted;
  logic [31:0]       load_ext;
  logic [3:0]        be;
  logic [31:0]       wd;

  assign widx      = req_addr[ADDR_W-1:2];
  assign accept    = req_valid && req_ready;
  assign state_dbg = state;

  // State register and sweep pointer; reset restarts the sweep from word 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state, sweep pointer advance, ready and busy.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      S_CLEAR: begin
        busy = 1'b1;
        if (ptr == LAST_PTR) begin
          state_nxt = S_RUN;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + PTR_ONE;
        end
      end
      S_RUN: begin
        req_ready = !clear;
        if (clear) begin
          state_nxt = S_CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_RUN;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Alignment check: halfwords need addr[0]=0, words addr[1:0]=0, size 3 faults.
  always_comb begin
    fault = 1'b0;
    case (req_size)
      2'd0:    fault = 1'b0;
      2'd1:    fault = req_addr[0];
      2'd2:    fault = |req_addr[1:0];
      default: fault = 1'b1;
    endcase
  end

  // Store lane enables and data replicated onto every lane it may land in.
  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    case (req_size)
      2'd0: begin
        be = 4'b0001 << req_addr[1:0];
        wd = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be = req_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        be = 4'b1111;
        wd = req_wdata;
      end
      default: begin
        be = 4'b0000;
        wd = req_wdata;
      end
    endcase
  end

  // Load path: pick the addressed lane, move it to bit 0, then extend.
  assign rword   = mem[widx];
  assign shifted = rword >> {req_addr[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (req_size)
      2'd0:    load_ext = req_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'h000000, shifted[7:0]};
      2'd1:    load_ext = req_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'h0000, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Memory array: sweep zeroes one word per cycle, otherwise byte-lane stores.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[ptr] <= '0;
    end else if (accept && req_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  // Response register: one pulse per accepted request, data held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_misalign <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_misalign <= fault;
        rsp_rdata    <= (fault || req_we) ? 32'h0 : load_ext;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-array reference model, per-cycle compare,
// directed literal checks and randomized traffic with occasional clears.
module tb_data_mem_ctrl;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 16;
  localparam int NBYTES = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        clear = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;
  logic        busy;
  logic        state_dbg;

  int vectors = 0;
  int miscompares = 0;

  data_mem_ctrl #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .clear(clear),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as a plain byte array, sweep as a cycle countdown.
  logic [7:0]  m_mem [NBYTES];
  int          m_busy = DEPTH;
  logic        m_rv = 1'b0;
  logic [31:0] m_rd = '0;
  logic        m_mis = 1'b0;
  bit          m_acc;

  function automatic bit model_fault(input logic [5:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] a, input logic [1:0] sz, input logic sg);
    int b;
    logic [7:0]  v8;
    logic [15:0] v16;
    b = a;
    if (sz == 2'd0) begin
      v8 = m_mem[b];
      return sg ? {{24{v8[7]}}, v8} : {24'h0, v8};
    end
    if (sz == 2'd1) begin
      v16 = {m_mem[b+1], m_mem[b]};
      return sg ? {{16{v16[15]}}, v16} : {16'h0, v16};
    end
    return {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = DEPTH;
      m_rv   = 1'b0;
      m_rd   = '0;
      m_mis  = 1'b0;
      for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
    end else begin
      m_acc = req_valid && (m_busy == 0) && !clear;
      if (m_busy > 0) begin
        m_busy = m_busy - 1;
      end else if (clear) begin
        m_busy = DEPTH;
        for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
      end
      m_rv = m_acc;
      if (m_acc) begin
        if (model_fault(req_addr, req_size)) begin
          m_mis = 1'b1;
          m_rd  = '0;
        end else if (req_we) begin
          m_mis = 1'b0;
          m_rd  = '0;
          for (int k = 0; k < (1 << req_size); k++)
            m_mem[int'(req_addr) + k] = req_wdata[8*k +: 8];
        end else begin
          m_mis = 1'b0;
          m_rd  = model_load(req_addr, req_size, req_signed);
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("rsp_valid", rsp_valid, m_rv);
    check("rsp_rdata", rsp_rdata, m_rd);
    check("rsp_misalign", rsp_misalign, m_mis);
    check("busy", busy, m_busy > 0);
    check("state_dbg", state_dbg, m_busy > 0);
    check("req_ready", req_ready, (m_busy == 0) && !clear);
  end

  // Driver: one request, then literal check of its response.
  task automatic xact(input string name, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [5:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_m);
    #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    check({name, ".valid"}, rsp_valid, 1'b1);
    check({name, ".rdata"}, rsp_rdata, exp_d);
    check({name, ".mis"}, rsp_misalign, exp_m);
    #1 req_valid = 1'b0;
  endtask

  // Counts busy cycles until the sweep ends, bounded.
  task automatic count_sweep(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) n++;
      @(negedge clk);
    end
    check(name, n, 16);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    count_sweep("sweep_after_reset");
    xact("lw_3c", 1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, 32'h00000000, 1'b0);

    xact("sw_10", 1'b1, 2'd2, 1'b0, 6'h10, 32'hABCD1234, 32'h0, 1'b0);
    xact("lw_10", 1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 32'hABCD1234, 1'b0);
    xact("lb_13", 1'b0, 2'd0, 1'b1, 6'h13, 32'h0, 32'hFFFFFFAB, 1'b0);
    xact("lbu_13", 1'b0, 2'd0, 1'b0, 6'h13, 32'h0, 32'h000000AB, 1'b0);
    xact("lh_10", 1'b0, 2'd1, 1'b1, 6'h10, 32'h0, 32'h00001234, 1'b0);
    xact("lh_12", 1'b0, 2'd1, 1'b1, 6'h12, 32'h0, 32'hFFFFABCD, 1'b0);
    xact("lhu_12", 1'b0, 2'd1, 1'b0, 6'h12, 32'h0, 32'h0000ABCD, 1'b0);

    xact("sb_11", 1'b1, 2'd0, 1'b0, 6'h11, 32'h0000005A, 32'h0, 1'b0);
    xact("sh_12", 1'b1, 2'd1, 1'b0, 6'h12, 32'h0000BEEF, 32'h0, 1'b0);
    xact("lw_10b", 1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 32'hBEEF5A34, 1'b0);

    xact("lw_12_mis", 1'b0, 2'd2, 1'b0, 6'h12, 32'h0, 32'h0, 1'b1);
    xact("sh_11_mis", 1'b1, 2'd1, 1'b0, 6'h11, 32'h0000FFFF, 32'h0, 1'b1);
    xact("sz3_00_mis", 1'b1, 2'd3, 1'b0, 6'h00, 32'hDEADBEEF, 32'h0, 1'b1);
    xact("lw_00", 1'b0, 2'd2, 1'b0, 6'h00, 32'h0, 32'h00000000, 1'b0);
    xact("lw_10c", 1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 32'hBEEF5A34, 1'b0);

    // Clear mid-stream: a pending load is refused the same cycle.
    #1;
    clear     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'd2;
    req_addr  = 6'h10;
    #1 check("ready_drop_clear", req_ready, 1'b0);
    @(negedge clk);
    check("no_rsp_on_clear", rsp_valid, 1'b0);
    #1;
    clear     = 1'b0;
    req_valid = 1'b0;
    count_sweep("sweep_after_clear");
    xact("lw_10_cleared", 1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 32'h00000000, 1'b0);

    // Reset in the middle of a sweep restarts it from word 0.
    xact("sw_10_again", 1'b1, 2'd2, 1'b0, 6'h10, 32'h11223344, 32'h0, 1'b0);
    #1 clear = 1'b1;
    @(negedge clk);
    #1 clear = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rsp_valid_in_reset", rsp_valid, 1'b0);
    #1 reset = 1'b1;
    count_sweep("sweep_after_mid_reset");
    xact("lw_10_after_reset", 1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 32'h00000000, 1'b0);

    // Randomized traffic with rare clears; the per-cycle compare does the checking.
    for (int i = 0; i < 600; i++) begin
      #1;
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = $urandom_range(0, 1);
      req_size   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      req_signed = $urandom_range(0, 1);
      req_addr   = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) req_addr = req_addr & ~(6'((1 << req_size) - 1));
      req_wdata  = $urandom;
      clear      = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    #1;
    req_valid = 1'b0;
    clear     = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
